// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low key matrix one column at a time, assembles 16-bit
// frames, debounces them over whole frames and reports single-key presses as
// a 4-bit code with a valid/ack handshake.
// Optional build macro KEYPAD_REPEAT_EN: while the same single key stays
// accepted, a further press event is issued every REPEAT_FRAMES accepted
// frames after the initial event.

module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 250,  // clk cycles per column dwell (>=2)
    parameter int DEBOUNCE_SCANS = 3,    // identical frames needed to accept (>=1)
    parameter int REPEAT_FRAMES  = 25    // auto-repeat interval in accepted frames
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    output logic [3:0] keyboard_col,
    input  logic [3:0] keyboard_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    // Position of the single set bit of a one-hot frame; 0 when empty.
    function automatic logic [3:0] encode_key(input logic [15:0] f);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (f[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Scan registers
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_q;
    logic [15:0]      raw_q;
    logic [3:0]       keyboard_col_q;

    // Debounce registers
    logic [15:0]      prev_raw_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic             prev_none_q;
    logic             key_down_q;

    // Handshake registers
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic             overrun_q;

    // Combinational decode
    logic             dwell_done;
    logic             frame_done;
    logic [1:0]       col_d;
    logic [15:0]      raw_d;
    logic [15:0]      frame;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             is_none;
    logic             is_single;
    logic [3:0]       frame_code;
    logic             first_event;
    logic             press_event;

    // Column timing, frame assembly, debounce arithmetic and press detection.
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        dwell_done  = scan_en && (div_q == DIV_LAST);
        frame_done  = dwell_done && (col_q == 2'd3);
        col_d       = col_q + 2'd1;
        raw_d       = raw_q;
        if (dwell_done) begin
            raw_d[{col_q, 2'b00} +: 4] = ~keyboard_row;
        end
        // The completed frame includes column 3 sampled on this very edge.
        frame       = raw_d;
        cnt_d       = CNT_W'(1);
        if (frame == prev_raw_q) begin
            cnt_d = (deb_cnt_q == CNT_MAX) ? CNT_MAX : deb_cnt_q + CNT_W'(1);
        end
        accept      = frame_done && (cnt_d == CNT_MAX);
        is_none     = (frame == 16'h0000);
        is_single   = $onehot(frame);
        frame_code  = encode_key(frame);
        // A press only counts when the previously accepted state held no keys.
        first_event = accept && is_single && prev_none_q;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [15:0]      stable_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_active_q;
    logic             repeat_event;

    // A repeat fires when the same single key has been re-accepted REPEAT_FRAMES times.
    always_comb begin
        repeat_event = accept && rep_active_q && is_single &&
                       (frame == stable_q) && (rep_cnt_q == REP_LAST);
    end

    // Repeat bookkeeping: counts accepted frames of an unchanged, already reported key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q     <= '0;
            rep_cnt_q    <= '0;
            rep_active_q <= 1'b0;
        end else if (accept) begin
            stable_q <= frame;
            if (frame != stable_q) begin
                rep_cnt_q    <= '0;
                rep_active_q <= first_event;
            end else if (rep_active_q && is_single) begin
                rep_cnt_q <= (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + REP_W'(1);
            end
        end
    end

    assign press_event = first_event || repeat_event;
`else
    assign press_event = first_event;
`endif

    // Column divider and drive; disabling the scan parks the matrix and drops the partial frame.
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= '0;
            col_q          <= 2'd0;
            raw_q          <= '0;
            keyboard_col_q <= 4'b1110;
        end else if (!scan_en) begin
            div_q          <= '0;
            col_q          <= 2'd0;
            raw_q          <= '0;
            keyboard_col_q <= 4'b1111;
        end else if (dwell_done) begin
            div_q          <= '0;
            col_q          <= col_d;
            raw_q          <= raw_d;
            keyboard_col_q <= ~(4'b0001 << col_d);
        end else begin
            div_q          <= div_q + DIV_W'(1);
            keyboard_col_q <= ~(4'b0001 << col_q);
        end
    end

    // Whole-frame debounce and accepted-state tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_raw_q  <= '0;
            deb_cnt_q   <= '0;
            prev_none_q <= 1'b1;
            key_down_q  <= 1'b0;
        end else if (frame_done) begin
            prev_raw_q <= frame;
            deb_cnt_q  <= cnt_d;
            if (accept) begin
                prev_none_q <= is_none;
                key_down_q  <= is_single;
            end
        end
    end

    // Valid/ack handshake with sticky overrun; an ack always wins over a coincident event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            overrun_q   <= 1'b0;
        end else if (key_valid_q && key_ack) begin
            key_valid_q <= 1'b0;
            overrun_q   <= press_event;
        end else if (press_event) begin
            if (key_valid_q) begin
                overrun_q <= 1'b1;
            end else begin
                key_valid_q <= 1'b1;
                key_code_q  <= frame_code;
            end
        end
    end

    assign keyboard_col = keyboard_col_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_down     = key_down_q;
    assign overrun      = overrun_q;

endmodule
